// File: rtl/mul_share_arb_pkg.sv
// Shared definitions for the multiplier-sharing arbiter: tag width helper and counter width.
package mul_share_arb_pkg;

  localparam int CNT_W = 32;

  typedef logic [CNT_W-1:0] cnt_t;

  // Requester tag width; a single requester still carries a 1-bit tag.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mul_share_arb_rr.sv
// Combinational round-robin picker: first set request at or above ptr (mod N_REQ) wins.
// Zero latency; grants nothing when en is low.
module mul_share_arb_rr
  import mul_share_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = id_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  win,
  output logic             any
);

  logic [ID_W:0] idx;

  always_comb begin
    gnt = '0;
    win = '0;
    any = 1'b0;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = {1'b0, ptr} + (ID_W+1)'(i);
      if (idx >= (ID_W+1)'(N_REQ)) idx = idx - (ID_W+1)'(N_REQ);
      if (en && !any && req[idx[ID_W-1:0]]) begin
        any = 1'b1;
        win = idx[ID_W-1:0];
      end
    end
    if (any) gnt[win] = 1'b1;
  end

endmodule

// File: rtl/mul_share_arb.sv
// Round-robin share of one pipelined unsigned multiplier among N_REQ requesters; results tagged by requester.
// Latency MUL_STAGES cycles from grant to res_valid; a held result (res_ready low) freezes the whole pipe and blocks grants.
// Optional MUL_SHARE_ARB_STATS_EN adds per-requester grant counters and a stall counter.
module mul_share_arb
  import mul_share_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int A_W        = 16,
  parameter int B_W        = 16,
  parameter int MUL_STAGES = 3
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic                      arb_en,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*A_W-1:0]      req_a,
  input  logic [N_REQ*B_W-1:0]      req_b,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [id_w(N_REQ)-1:0]    res_id,
  output logic [A_W+B_W-1:0]        res_p,
  output logic                      busy
`ifdef MUL_SHARE_ARB_STATS_EN
  ,
  input  logic                      stat_clr,
  output logic [N_REQ*CNT_W-1:0]    stat_grant_cnt,
  output logic [CNT_W-1:0]          stat_stall_cnt
`endif
);

  localparam int ID_W = id_w(N_REQ);
  localparam int P_W  = A_W + B_W;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
    logic [P_W-1:0]  p;
  } stage_t;

  stage_t          st [MUL_STAGES];
  logic            adv;
  logic            any;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] win;
  logic [A_W-1:0]  a_sel;
  logic [B_W-1:0]  b_sel;
  logic [P_W-1:0]  prod;

  assign adv = !(res_valid && !res_ready);

  mul_share_arb_rr #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr (
    .req (req_valid),
    .ptr (ptr),
    .en  (adv && arb_en),
    .gnt (req_ready),
    .win (win),
    .any (any)
  );

  // The multiply sits ahead of stage 0; the remaining stages only carry the product.
  assign a_sel = req_a[win*A_W +: A_W];
  assign b_sel = req_b[win*B_W +: B_W];
  assign prod  = P_W'(a_sel) * P_W'(b_sel);

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      for (int k = 0; k < MUL_STAGES; k++) st[k] <= '0;
      ptr <= '0;
    end else begin
      if (any) ptr <= (win == ID_W'(N_REQ-1)) ? '0 : win + 1'b1;
      if (adv) begin
        st[0] <= '{vld: any, id: win, p: prod};
        for (int k = 1; k < MUL_STAGES; k++) st[k] <= st[k-1];
      end
    end
  end

  assign res_valid = st[MUL_STAGES-1].vld;
  assign res_id    = st[MUL_STAGES-1].id;
  assign res_p     = st[MUL_STAGES-1].p;

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < MUL_STAGES; k++) busy = busy | st[k].vld;
  end

`ifdef MUL_SHARE_ARB_STATS_EN
  cnt_t gcnt [N_REQ];
  cnt_t scnt;

  // Clear wins over a same-cycle increment; all counters saturate.
  always_ff @(posedge ap_clk) begin
    if (ap_rst || stat_clr) begin
      for (int i = 0; i < N_REQ; i++) gcnt[i] <= '0;
      scnt <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++)
        if (req_valid[i] && req_ready[i] && gcnt[i] != '1) gcnt[i] <= gcnt[i] + 1'b1;
      if (!adv && scnt != '1) scnt <= scnt + 1'b1;
    end
  end

  always_comb begin
    stat_grant_cnt = '0;
    for (int i = 0; i < N_REQ; i++) stat_grant_cnt[i*CNT_W +: CNT_W] = gcnt[i];
  end

  assign stat_stall_cnt = scnt;
`endif

endmodule

// File: tb/tb_mul_share_arb.sv
// Scoreboard bench for mul_share_arb: driver predicts grants/valids and queues expected results; monitor checks them.
module tb_mul_share_arb;

  logic         ap_clk = 1'b0;
  logic         ap_rst = 1'b1;
  logic         arb_en = 1'b0;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_ready;
  logic [63:0]  req_a = '0;
  logic [63:0]  req_b = '0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [1:0]   res_id;
  logic [31:0]  res_p;
  logic         busy;
`ifdef MUL_SHARE_ARB_STATS_EN
  logic         stat_clr = 1'b0;
  logic         clr_req = 1'b0;
  logic [127:0] stat_grant_cnt;
  logic [31:0]  stat_stall_cnt;
`endif

  mul_share_arb dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .arb_en    (arb_en),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_p     (res_p),
    .busy      (busy)
`ifdef MUL_SHARE_ARB_STATS_EN
    ,
    .stat_clr       (stat_clr),
    .stat_grant_cnt (stat_grant_cnt),
    .stat_stall_cnt (stat_stall_cnt)
`endif
  );

  initial forever #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] p;
  } exp_t;

  exp_t        q[$];
  logic [15:0] ta [4];
  logic [15:0] tbv [4];
  logic [31:0] ep [4];   // hand-computed products for the current operands
  bit          mv [3];   // predicted stage valids
  int          mptr = 0;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock of stimulus; inputs change on the falling edge, checks follow 1 time unit later.
  task automatic cyc(input logic [3:0] v, input logic rr, input logic en, input logic rst);
    int         w;
    logic       madv;
    logic [3:0] erdy;
    exp_t       e;
    @(negedge ap_clk);
    req_valid = v;
    res_ready = rr;
    arb_en    = en;
    ap_rst    = rst;
    for (int i = 0; i < 4; i++) begin
      req_a[i*16 +: 16] = ta[i];
      req_b[i*16 +: 16] = tbv[i];
    end
`ifdef MUL_SHARE_ARB_STATS_EN
    stat_clr = clr_req;
`endif
    #1;
    chk("res_valid", res_valid, mv[2]);
    chk("busy", busy, mv[0] | mv[1] | mv[2]);
    madv = !(mv[2] && !rr);
    w = -1;
    if (madv && en)
      for (int k = 0; k < 4; k++)
        if (w < 0 && v[(mptr + k) % 4]) w = (mptr + k) % 4;
    erdy = (w >= 0) ? 4'(1 << w) : 4'b0000;
    chk("req_ready", req_ready, erdy);
    if (rst) begin
      for (int k = 0; k < 3; k++) mv[k] = 1'b0;
      mptr = 0;
      q.delete();
    end else if (madv) begin
      mv[2] = mv[1];
      mv[1] = mv[0];
      mv[0] = (w >= 0);
      if (w >= 0) begin
        e.id = 2'(w);
        e.p  = ep[w];
        q.push_back(e);
        mptr = (w + 1) % 4;
      end
    end
  endtask

  // Monitor: compares the head of the queue whenever a result is presented, pops on handshake.
  initial forever begin
    @(negedge ap_clk);
    #2;
    if (res_valid && !ap_rst) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL res_unexpected: got id=%0d p=%0h expected no result at %0t", res_id, res_p, $time);
      end else begin
        chk("res_id", res_id, q[0].id);
        chk("res_p", res_p, q[0].p);
        if (res_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      ta[i] = '0; tbv[i] = '0; ep[i] = '0;
    end
    for (int k = 0; k < 3; k++) mv[k] = 1'b0;

    // Reset state
    cyc(4'b0000, 1'b0, 1'b0, 1'b1);
    cyc(4'b0000, 1'b0, 1'b0, 1'b1);
    chk("rst_res_id", res_id, 2'd0);
    chk("rst_res_p", res_p, 32'd0);
`ifdef MUL_SHARE_ARB_STATS_EN
    chk("rst_stall_cnt", stat_stall_cnt, 32'd0);
`endif

    // Single op from requester 0: 3*5
    ta[0] = 16'h0003; tbv[0] = 16'h0005; ep[0] = 32'h0000000F;
    cyc(4'b0001, 1'b1, 1'b1, 1'b0);
    repeat (4) cyc(4'b0000, 1'b1, 1'b1, 1'b0);

    // All requesters streaming; requester 2 carries the full-scale operands
    ta[0] = 16'h0011; tbv[0] = 16'h0010; ep[0] = 32'h00000110;
    ta[1] = 16'h0102; tbv[1] = 16'h0003; ep[1] = 32'h00000306;
    ta[2] = 16'hFFFF; tbv[2] = 16'hFFFF; ep[2] = 32'hFFFE0001;
    ta[3] = 16'h1234; tbv[3] = 16'h0002; ep[3] = 32'h00002468;
    repeat (12) cyc(4'b1111, 1'b1, 1'b1, 1'b0);

    // Five-cycle output stall with the pipe full
    repeat (5) cyc(4'b1111, 1'b0, 1'b1, 1'b0);
    cyc(4'b1111, 1'b1, 1'b1, 1'b0);
`ifdef MUL_SHARE_ARB_STATS_EN
    chk("stall_cnt", stat_stall_cnt, 32'd5);
`endif
    repeat (4) cyc(4'b1111, 1'b1, 1'b1, 1'b0);
    repeat (4) cyc(4'b0000, 1'b1, 1'b1, 1'b0);

    // Reset with three ops in flight, then grant restarts from requester 0
    repeat (3) cyc(4'b1111, 1'b1, 1'b1, 1'b0);
    cyc(4'b0000, 1'b1, 1'b1, 1'b1);
    cyc(4'b0000, 1'b1, 1'b1, 1'b0);
    cyc(4'b1100, 1'b1, 1'b1, 1'b0);
    chk("grant_after_rst", req_ready, 4'b0100);
    cyc(4'b1100, 1'b1, 1'b1, 1'b0);
    // Grants disabled while the two ops drain
    repeat (5) cyc(4'b1111, 1'b1, 1'b0, 1'b0);

`ifdef MUL_SHARE_ARB_STATS_EN
    cyc(4'b0000, 1'b1, 1'b1, 1'b1);
    repeat (10) cyc(4'b0010, 1'b1, 1'b1, 1'b0);
    clr_req = 1'b1;
    cyc(4'b0010, 1'b1, 1'b1, 1'b0);
    chk("grant_cnt1", stat_grant_cnt[32 +: 32], 32'd10);
    clr_req = 1'b0;
    cyc(4'b0000, 1'b1, 1'b1, 1'b0);
    chk("grant_cnt1_clr", stat_grant_cnt[32 +: 32], 32'd0);
`endif

    repeat (6) cyc(4'b0000, 1'b1, 1'b1, 1'b0);
    chk("sb_empty", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
